multicycle_cpu: RTL and testbench

//  Multicycle ARM-subset core: next generation of the single-cycle microprocessor. One unified external memory port

---
 rtl/multicycle_cpu.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_multicycle_cpu.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_cpu.sv
// multicycle_cpu
//   Multicycle ARM-subset core with a single unified memory port. Instructions
//   and data share one req/ready handshake, so any access may stall for any
//   number of wait states. Internal 16x32 register file, NZCV flags and an
//   FSM controller that drives every memory-side output from a register.
//
// Parameters
//   ADDR_W    byte-address width of the PC and mem_addr
//   RESET_PC  PC value loaded on reset
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-low reset
//   mem_req       out  memory transaction request
//   mem_we        out  1 = write, 0 = read (meaningful while mem_req)
//   mem_addr      out  word-aligned byte address
//   mem_wdata     out  store data
//   mem_rdata     in   read data, valid with mem_ready
//   mem_ready     in   transaction completes on an edge with mem_req & mem_ready
//   halted        out  core parked in HALT
//   perf_cycles   out  cycles since reset         (MCPU_PERF_EN only)
//   perf_retired  out  instructions retired       (MCPU_PERF_EN only)
//
// Build option
//   MCPU_PERF_EN  adds the two performance counters and their ports.

module multicycle_cpu #(
    parameter int                ADDR_W   = 13,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              halted
`ifdef MCPU_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_retired
`endif
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MEMADDR,
        S_MEMREAD, S_MEMWB, S_MEMWRITE, S_BRANCH, S_HALT
    } state_t;

    localparam logic [3:0]        CMD_AND = 4'b0000;
    localparam logic [3:0]        CMD_SUB = 4'b0010;
    localparam logic [3:0]        CMD_ADD = 4'b0100;
    localparam logic [3:0]        CMD_CMP = 4'b1010;
    localparam logic [3:0]        CMD_ORR = 4'b1100;
    localparam logic [ADDR_W-1:0] ADDR_ALIGN = ~ADDR_W'(3);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       ir;
    logic [31:0]       regs [16];
    logic [31:0]       opa, opb, rdval, result;
    logic              flag_n, flag_z, flag_c, flag_v;

    // Instruction fields, always taken from the latched instruction register
    logic [3:0]  cond, cmd, rn, rd, rm;
    logic [1:0]  op;
    logic        i_bit, s_bit, u_bit, l_bit, is_halt;
    logic [7:0]  imm8;
    logic [11:0] imm12;

    assign cond    = ir[31:28];
    assign op      = ir[27:26];
    assign i_bit   = ir[25];
    assign cmd     = ir[24:21];
    assign u_bit   = ir[23];
    assign s_bit   = ir[20];
    assign l_bit   = ir[20];
    assign rn      = ir[19:16];
    assign rd      = ir[15:12];
    assign rm      = ir[3:0];
    assign imm8    = ir[7:0];
    assign imm12   = ir[11:0];
    assign is_halt = (ir == 32'hFFFF_FFFF);

    // pc already points past the instruction during DECODE, so R15 reads as
    // instruction address + 8 by adding one more word.
    logic [31:0] r15val, rn_val, rm_val, rd_val;
    assign r15val = 32'(pc) + 32'd4;
    assign rn_val = (rn == 4'd15) ? r15val : regs[rn];
    assign rm_val = (rm == 4'd15) ? r15val : regs[rm];
    assign rd_val = (rd == 4'd15) ? r15val : regs[rd];

    // Address arithmetic wraps at ADDR_W bits and is always word aligned
    logic [ADDR_W-1:0] mem_ea, br_target, wb_target;
    assign mem_ea    = ADDR_W'(u_bit ? opa + 32'(imm12) : opa - 32'(imm12)) & ADDR_ALIGN;
    assign br_target = ADDR_W'(r15val + {{6{ir[23]}}, ir[23:0], 2'b00}) & ADDR_ALIGN;
    assign wb_target = ADDR_W'(result) & ADDR_ALIGN;

    // Condition check against the current flags; the 1111 code (other than
    // the HALT word) executes unconditionally like AL.
    logic cond_pass;
    always_comb begin
        cond_pass = 1'b1;
        case (cond)
            4'h0: cond_pass = flag_z;
            4'h1: cond_pass = !flag_z;
            4'h2: cond_pass = flag_c;
            4'h3: cond_pass = !flag_c;
            4'h4: cond_pass = flag_n;
            4'h5: cond_pass = !flag_n;
            4'h6: cond_pass = flag_v;
            4'h7: cond_pass = !flag_v;
            4'h8: cond_pass = flag_c && !flag_z;
            4'h9: cond_pass = !flag_c || flag_z;
            4'hA: cond_pass = (flag_n == flag_v);
            4'hB: cond_pass = (flag_n != flag_v);
            4'hC: cond_pass = !flag_z && (flag_n == flag_v);
            4'hD: cond_pass = flag_z || (flag_n != flag_v);
            default: cond_pass = 1'b1;
        endcase
    end

    // ALU: subtraction carry is "no borrow"; logical ops leave C and V alone.
    // Unlisted commands pass operand 2 through like a move.
    logic [32:0] sum, diff;
    logic [31:0] alu_res;
    logic        alu_c, alu_v;
    assign sum  = {1'b0, opa} + {1'b0, opb};
    assign diff = {1'b0, opa} - {1'b0, opb};
    always_comb begin
        alu_res = opb;
        alu_c   = flag_c;
        alu_v   = flag_v;
        case (cmd)
            CMD_AND: alu_res = opa & opb;
            CMD_ORR: alu_res = opa | opb;
            CMD_ADD: begin
                alu_res = sum[31:0];
                alu_c   = sum[32];
                alu_v   = (opa[31] == opb[31]) && (sum[31] != opa[31]);
            end
            CMD_SUB, CMD_CMP: begin
                alu_res = diff[31:0];
                alu_c   = !diff[32];
                alu_v   = (opa[31] != opb[31]) && (diff[31] != opa[31]);
            end
            default: ;
        endcase
    end

    // Controller. Every transition back to FETCH raises the next fetch request
    // in the same edge so no idle cycle appears between instructions. The only
    // FETCH visit with mem_req low is the first one after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            ir        <= '0;
            opa       <= '0;
            opb       <= '0;
            rdval     <= '0;
            result    <= '0;
            flag_n    <= 1'b0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= RESET_PC;
            mem_wdata <= '0;
            halted    <= 1'b0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end else if (mem_ready) begin
                        ir      <= mem_rdata;
                        pc      <= pc + ADDR_W'(4);
                        mem_req <= 1'b0;
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    opa   <= rn_val;
                    opb   <= i_bit ? {24'b0, imm8} : rm_val;
                    rdval <= rd_val;
                    if (is_halt) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else if (!cond_pass || op == 2'b11) begin
                        mem_req  <= 1'b1;
                        mem_addr <= pc;
                        state    <= S_FETCH;
                    end else begin
                        case (op)
                            2'b00:   state <= S_EXEC;
                            2'b01:   state <= S_MEMADDR;
                            default: state <= S_BRANCH;
                        endcase
                    end
                end
                S_EXEC: begin
                    result <= alu_res;
                    if (s_bit || cmd == CMD_CMP) begin
                        flag_n <= alu_res[31];
                        flag_z <= (alu_res == 32'd0);
                        flag_c <= alu_c;
                        flag_v <= alu_v;
                    end
                    if (cmd == CMD_CMP) begin
                        mem_req  <= 1'b1;
                        mem_addr <= pc;
                        state    <= S_FETCH;
                    end else begin
                        state <= S_ALUWB;
                    end
                end
                S_ALUWB, S_MEMWB: begin
                    mem_req <= 1'b1;
                    state   <= S_FETCH;
                    if (rd == 4'd15) begin
                        pc       <= wb_target;
                        mem_addr <= wb_target;
                    end else begin
                        regs[rd] <= result;
                        mem_addr <= pc;
                    end
                end
                S_MEMADDR: begin
                    mem_req  <= 1'b1;
                    mem_we   <= !l_bit;
                    mem_addr <= mem_ea;
                    if (!l_bit) mem_wdata <= rdval;
                    state    <= l_bit ? S_MEMREAD : S_MEMWRITE;
                end
                S_MEMREAD: begin
                    if (mem_ready) begin
                        result  <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= S_MEMWB;
                    end
                end
                S_MEMWRITE: begin
                    if (mem_ready) begin
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                        state    <= S_FETCH;
                    end
                end
                S_BRANCH: begin
                    pc       <= br_target;
                    mem_req  <= 1'b1;
                    mem_addr <= br_target;
                    state    <= S_FETCH;
                end
                S_HALT: ;
            endcase
        end
    end

`ifdef MCPU_PERF_EN
    // An instruction retires on the edge that sends the FSM back to FETCH.
    // The cycle counter freezes on the edge that recognises HALT.
    logic retire, halt_now;
    assign halt_now = (state == S_DECODE) && is_halt;
    assign retire   = ((state == S_DECODE) && !is_halt && (!cond_pass || op == 2'b11)) ||
                      ((state == S_EXEC) && cmd == CMD_CMP) ||
                      (state == S_ALUWB) || (state == S_MEMWB) || (state == S_BRANCH) ||
                      ((state == S_MEMWRITE) && mem_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cycles  <= '0;
            perf_retired <= '0;
        end else begin
            if (state != S_HALT && !halt_now) perf_cycles <= perf_cycles + 32'd1;
            if (retire) perf_retired <= perf_retired + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_cpu.sv
// tb_multicycle_cpu
//   Directed bench for multicycle_cpu with RESET_PC = 0x040. A behavioural
//   memory answers on the shared port and can insert wait states on reads of
//   address 0x010. Every accepted transaction is logged with its edge number
//   (edges counted from reset release) and compared against hand-built traces.

module tb_multicycle_cpu;

    localparam int ADDR_W = 13;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              mem_req, mem_we, mem_ready, halted;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;
`ifdef MCPU_PERF_EN
    logic [31:0]       perf_cycles, perf_retired;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int wait_n   = 0;
    int wcnt, cyc, hold10, halt_cyc, req_in_halt;

    logic [31:0] mem [0:2047];
    logic [63:0] trace [$];
    logic [63:0] expq  [$];

    multicycle_cpu #(.ADDR_W(ADDR_W), .RESET_PC(13'h040)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .halted       (halted)
`ifdef MCPU_PERF_EN
        ,
        .perf_cycles  (perf_cycles),
        .perf_retired (perf_retired)
`endif
    );

    always #5 clk = ~clk;

    // Memory reads are combinational; reads of 0x010 stall for wait_n cycles
    assign mem_rdata = mem[mem_addr[12:2]];
    assign mem_ready = !(mem_req && !mem_we && mem_addr == 13'h010 && wcnt < wait_n);

    // Edge counter: edge 1 is the first rising edge after reset release
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // Wait-state counter for the stalling address
    always @(posedge clk or negedge rst) begin
        if (!rst)                         wcnt <= 0;
        else if (mem_req && mem_ready)    wcnt <= 0;
        else if (mem_req && !mem_ready)   wcnt <= wcnt + 1;
    end

    // Count edges during which a read of 0x010 is being presented
    always @(posedge clk or negedge rst) begin
        if (!rst) hold10 <= 0;
        else if (mem_req && !mem_we && mem_addr == 13'h010) hold10 <= hold10 + 1;
    end

    // Any request while halted is an error
    always @(posedge clk or negedge rst) begin
        if (!rst) req_in_halt <= 0;
        else if (halted && mem_req) req_in_halt <= req_in_halt + 1;
    end

    // Remember the edge after which halted was first seen
    always @(negedge clk or negedge rst) begin
        if (!rst) halt_cyc <= 0;
        else if (halted && halt_cyc == 0) halt_cyc <= cyc;
    end

    function automatic logic [63:0] pack(input int c, input logic we,
                                         input logic [12:0] a, input logic [31:0] d);
        return {c[15:0], we, 2'b00, a, d};
    endfunction

    // Transaction logger: edge number, direction, address, data moved
    always @(posedge clk) begin
        if (!rst) trace.delete();
        else if (mem_req && mem_ready)
            trace.push_back(pack(cyc + 1, mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata));
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkTrace(input string name);
        checkOutput({name, "_len"}, 64'(trace.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size(); i++) begin
            logic [63:0] obs;
            obs = (i < trace.size()) ? trace[i] : '1;
            checkOutput($sformatf("%s_txn%0d", name, i), obs, expq[i]);
        end
    endtask

    task automatic loadProgram(input int prog);
        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
        mem[13'h010 >> 2] = 32'hDEAD_BEEF;
        case (prog)
            1: begin
                mem[16'h40 >> 2] = 32'hE280_1005;  // ADD  R1,R0,#5
                mem[16'h44 >> 2] = 32'hE291_2007;  // ADDS R2,R1,#7
                mem[16'h48 >> 2] = 32'hE580_2080;  // STR  R2,[R0,#0x80]
                mem[16'h4C >> 2] = 32'hE590_3010;  // LDR  R3,[R0,#0x10]
                mem[16'h50 >> 2] = 32'hE580_3084;  // STR  R3,[R0,#0x84]
                mem[16'h54 >> 2] = 32'hE351_0005;  // CMP  R1,#5
                mem[16'h58 >> 2] = 32'h1AFF_FFFE;  // BNE  -8
                mem[16'h5C >> 2] = 32'hE051_4002;  // SUBS R4,R1,R2
                mem[16'h60 >> 2] = 32'hE203_50F0;  // AND  R5,R3,#0xF0
                mem[16'h64 >> 2] = 32'hE185_6001;  // ORR  R6,R5,R1
                mem[16'h68 >> 2] = 32'h4580_4088;  // STRMI R4,[R0,#0x88]
                mem[16'h6C >> 2] = 32'hE580_608C;  // STR  R6,[R0,#0x8C]
                mem[16'h70 >> 2] = 32'h2580_6090;  // STRCS R6,[R0,#0x90]
                mem[16'h74 >> 2] = 32'hE351_0005;  // CMP  R1,#5
                mem[16'h78 >> 2] = 32'h0AFF_FFFE;  // BEQ  -8
            end
            2: begin
                mem[16'h40 >> 2] = 32'hE280_1005;  // ADD  R1,R0,#5
                mem[16'h44 >> 2] = 32'hE291_2007;  // ADDS R2,R1,#7
                mem[16'h48 >> 2] = 32'hE081_1002;  // ADD  R1,R1,R2
                mem[16'h4C >> 2] = 32'hFFFF_FFFF;  // HALT
            end
            default: begin
                mem[16'h40 >> 2] = 32'hE590_3010;  // LDR  R3,[R0,#0x10]
                mem[16'h44 >> 2] = 32'hFFFF_FFFF;  // HALT
            end
        endcase
    endtask

    // Hold reset, load a program, check reset outputs, release on a falling
    // edge and check that the first fetch request appears one edge later.
    task automatic applyStimulus(input int prog);
        rst = 1'b0;
        @(negedge clk);
        loadProgram(prog);
        repeat (2) @(negedge clk);
        checkOutput($sformatf("p%0d_reset_state", prog),
                    64'({mem_req, mem_we, halted, mem_addr, mem_wdata}),
                    64'({1'b0, 1'b0, 1'b0, 13'h040, 32'h0}));
        rst = 1'b1;
        @(negedge clk);
        checkOutput($sformatf("p%0d_first_req", prog),
                    64'({mem_req, mem_we, mem_addr}), 64'({1'b1, 1'b0, 13'h040}));
    endtask

    initial begin
        #1;
        // Program 1: arithmetic, loads/stores with wait states, conditions, branch loop
        $display("[TB] program 1: datapath, wait states, conditions, branches");
        wait_n = 3;
        applyStimulus(1);
        repeat (62) @(negedge clk);
        expq.delete();
        expq.push_back(pack( 2, 1'b0, 13'h040, 32'hE280_1005));
        expq.push_back(pack( 6, 1'b0, 13'h044, 32'hE291_2007));
        expq.push_back(pack(10, 1'b0, 13'h048, 32'hE580_2080));
        expq.push_back(pack(13, 1'b1, 13'h080, 32'h0000_000C));
        expq.push_back(pack(14, 1'b0, 13'h04C, 32'hE590_3010));
        expq.push_back(pack(20, 1'b0, 13'h010, 32'hDEAD_BEEF));
        expq.push_back(pack(22, 1'b0, 13'h050, 32'hE580_3084));
        expq.push_back(pack(25, 1'b1, 13'h084, 32'hDEAD_BEEF));
        expq.push_back(pack(26, 1'b0, 13'h054, 32'hE351_0005));
        expq.push_back(pack(29, 1'b0, 13'h058, 32'h1AFF_FFFE));
        expq.push_back(pack(31, 1'b0, 13'h05C, 32'hE051_4002));
        expq.push_back(pack(35, 1'b0, 13'h060, 32'hE203_50F0));
        expq.push_back(pack(39, 1'b0, 13'h064, 32'hE185_6001));
        expq.push_back(pack(43, 1'b0, 13'h068, 32'h4580_4088));
        expq.push_back(pack(46, 1'b1, 13'h088, 32'hFFFF_FFF9));
        expq.push_back(pack(47, 1'b0, 13'h06C, 32'hE580_608C));
        expq.push_back(pack(50, 1'b1, 13'h08C, 32'h0000_00E5));
        expq.push_back(pack(51, 1'b0, 13'h070, 32'h2580_6090));
        expq.push_back(pack(53, 1'b0, 13'h074, 32'hE351_0005));
        expq.push_back(pack(56, 1'b0, 13'h078, 32'h0AFF_FFFE));
        expq.push_back(pack(59, 1'b0, 13'h078, 32'h0AFF_FFFE));
        expq.push_back(pack(62, 1'b0, 13'h078, 32'h0AFF_FFFE));
        checkTrace("p1");
        checkOutput("p1_ldr_hold_cycles", 64'(hold10), 64'd4);

        // Program 2: three DP instructions then HALT
        $display("[TB] program 2: halt");
        wait_n = 0;
        applyStimulus(2);
        repeat (29) @(negedge clk);
        expq.delete();
        expq.push_back(pack( 2, 1'b0, 13'h040, 32'hE280_1005));
        expq.push_back(pack( 6, 1'b0, 13'h044, 32'hE291_2007));
        expq.push_back(pack(10, 1'b0, 13'h048, 32'hE081_1002));
        expq.push_back(pack(14, 1'b0, 13'h04C, 32'hFFFF_FFFF));
        checkTrace("p2");
        checkOutput("p2_halt_edge", 64'(halt_cyc), 64'd15);
        checkOutput("p2_halted_idle", 64'({halted, mem_req}), 64'({1'b1, 1'b0}));
        checkOutput("p2_req_in_halt", 64'(req_in_halt), 64'd0);
`ifdef MCPU_PERF_EN
        checkOutput("p2_perf_retired", 64'(perf_retired), 64'd3);
        checkOutput("p2_perf_cycles", 64'(perf_cycles), 64'd14);
`endif

        // Program 3: reset pulse while an LDR is stalled, then a clean rerun
        $display("[TB] program 3: reset during a stalled load");
        wait_n = 1000;
        applyStimulus(3);
        repeat (9) @(negedge clk);
        checkOutput("p3_ldr_pending", 64'({mem_req, mem_we, mem_addr}),
                    64'({1'b1, 1'b0, 13'h010}));
        #2 rst = 1'b0;
        #1 checkOutput("p3_async_abort", 64'({mem_req, mem_we, mem_addr}),
                       64'({1'b0, 1'b0, 13'h040}));
        wait_n = 0;
        applyStimulus(3);
        repeat (9) @(negedge clk);
        expq.delete();
        expq.push_back(pack(2, 1'b0, 13'h040, 32'hE590_3010));
        expq.push_back(pack(5, 1'b0, 13'h010, 32'hDEAD_BEEF));
        expq.push_back(pack(7, 1'b0, 13'h044, 32'hFFFF_FFFF));
        checkTrace("p3");
        checkOutput("p3_halt_edge", 64'(halt_cyc), 64'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
